// File: rtl/morphing_periph_pkg.sv
// Shared types and default sizing for the peripheral-chain bring-up blocks.
// Provides the delay-probe FSM state encoding and default measurement limits.
package morphing_periph_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int DEF_MAX_DLY = 128;
    localparam int DEF_QUIET   = 4;
    localparam int DEF_CW      = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that stops at MAX and flags when it sits there.
// Clear takes priority over enable; reset is synchronous and active-low.
module sat_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable && (count != MAX_V)) begin
            count <= count + W'(1);
        end
    end

    assign at_max = (count == MAX_V);

endmodule

// File: rtl/delay_probe_meter.sv
// Measures an external delay path: waits for a quiet path, fires a one-cycle probe,
// and reports the echo latency in cycles or a timeout after MAX_DLY cycles.
module delay_probe_meter
    import morphing_periph_pkg::*;
#(
    parameter int MAX_DLY = DEF_MAX_DLY,
    parameter int QUIET   = DEF_QUIET,
    parameter int CW      = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          probe_out,
    input  logic          echo_in,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic          glitch,
    output logic [CW-1:0] dly_cnt
);

    localparam int QW = $clog2(QUIET + 1);

    state_t          state, state_nxt;
    logic            probe_nxt, busy_nxt, done_nxt, timeout_nxt, glitch_nxt;
    logic [CW-1:0]   dly_nxt;
    logic            q_clr, q_en, q_at_max;
    logic            w_clr, w_en, w_at_max;
    logic [QW-1:0]   quiet_cnt_unused;
    logic [CW-1:0]   w_cnt;

    // Terminal value is QUIET-1: the probe fires on the edge that would make it QUIET.
    sat_counter #(.W(QW), .MAX(QUIET - 1)) u_quiet_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (q_clr),
        .enable (q_en),
        .count  (quiet_cnt_unused),
        .at_max (q_at_max)
    );

    sat_counter #(.W(CW), .MAX(MAX_DLY)) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clr),
        .enable (w_en),
        .count  (w_cnt),
        .at_max (w_at_max)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            probe_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            glitch    <= 1'b0;
            dly_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            probe_out <= probe_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            timeout   <= timeout_nxt;
            glitch    <= glitch_nxt;
            dly_cnt   <= dly_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        probe_nxt   = 1'b0;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        glitch_nxt  = glitch;
        dly_nxt     = dly_cnt;
        q_clr       = 1'b0;
        q_en        = 1'b0;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = FLUSH;
                    q_clr      = 1'b1;
                    glitch_nxt = 1'b0;
                end
            end
            FLUSH: begin
                if (echo_in) begin
                    q_clr      = 1'b1;
                    glitch_nxt = 1'b1;
                end else if (q_at_max) begin
                    state_nxt = WAIT;
                    probe_nxt = 1'b1;
                    w_clr     = 1'b1;
                end else begin
                    q_en = 1'b1;
                end
            end
            WAIT: begin
                // An echo on the last allowed cycle is still a valid measurement.
                if (echo_in) begin
                    dly_nxt   = w_cnt;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (w_at_max) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    w_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == FLUSH) || (state_nxt == WAIT);
    end

endmodule

// File: tb/tb_delay_probe_meter.sv
// Bench for delay_probe_meter: a behavioural delay line closes the probe/echo loop,
// and each measurement is judged from wire-level event times and the delay rules.
module tb_delay_probe_meter;

    localparam int MAX_DLY = 128;
    localparam int QUIET   = 4;
    localparam int CW      = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          probe_out;
    logic          echo_in;
    logic          busy, done, timeout, glitch;
    logic [CW-1:0] dly_cnt;

    int            depth = -1;     // -1: path tied low, 0: wire, N: N registers
    bit            force_hi = 1'b0;
    bit            line_clr = 1'b0;
    logic [255:0]  hist = '0;

    int            checks = 0;
    int            errors = 0;
    int            exp_dly = 0;

    delay_probe_meter #(.MAX_DLY(MAX_DLY), .QUIET(QUIET), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .probe_out (probe_out),
        .echo_in   (echo_in),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .glitch    (glitch),
        .dly_cnt   (dly_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) hist <= line_clr ? '0 : {hist[254:0], probe_out};

    always_comb begin
        echo_in = force_hi;
        if (depth == 0) echo_in = force_hi | probe_out;
        else if (depth > 0 && depth <= 256) echo_in = force_hi | hist[8'(depth - 1)];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One measurement; k counts samples after the edge that accepted start.
    task automatic measure(input string tag, input int d, input int hi, input int exp_kp,
                           input bit exp_glitch, input bit keep_line, input int restart_at);
        int k, kp, ke, pw, nbusy, nbad, extra, m;
        bit fin;
        if (!keep_line) begin
            line_clr = 1'b1;
            tick();
            line_clr = 1'b0;
        end
        depth = d;
        force_hi = (hi > 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0; kp = -1; ke = -1; pw = 0; nbusy = 0; nbad = 0; fin = 1'b0;
        while (!fin && k < 400) begin
            tick();
            k++;
            if (k == restart_at) start = 1'b1;
            else if (k == restart_at + 1) start = 1'b0;
            if (k <= hi && (!busy || probe_out)) nbad++;
            if (k == hi) force_hi = 1'b0;
            if (probe_out) begin
                pw++;
                if (kp < 0) kp = k;
            end
            if (kp >= 0 && ke < 0 && echo_in) ke = k;
            if (done || timeout) fin = 1'b1;
            else if (!busy) nbusy++;
        end
        start = 1'b0;
        force_hi = 1'b0;
        chk({tag, " finished"}, int'(fin), 1);
        chk({tag, " probe rise"}, kp, exp_kp);
        chk({tag, " probe width"}, pw, 1);
        chk({tag, " busy gap"}, nbusy, 0);
        if (hi > 0) chk({tag, " flush hold"}, nbad, 0);
        chk({tag, " glitch"}, int'(glitch), int'(exp_glitch));
        chk({tag, " busy end"}, int'(busy), 0);
        m = (d < 0) ? MAX_DLY + 1 : d;
        if (m <= MAX_DLY) begin
            exp_dly = m;
            chk({tag, " done"}, int'(done), 1);
            chk({tag, " timeout"}, int'(timeout), 0);
            chk({tag, " wire count"}, ke - kp, m);
            chk({tag, " dly_cnt"}, int'(dly_cnt), exp_dly);
            chk({tag, " done time"}, k - kp, m + 1);
        end else begin
            chk({tag, " done"}, int'(done), 0);
            chk({tag, " timeout"}, int'(timeout), 1);
            chk({tag, " dly_cnt held"}, int'(dly_cnt), exp_dly);
            chk({tag, " timeout time"}, k - kp, MAX_DLY + 1);
        end
        extra = 0;
        repeat (8) begin
            tick();
            if (done || timeout || busy || probe_out) extra++;
        end
        chk({tag, " idle after"}, extra, 0);
    endtask

    initial begin
        int k, np, nd, nbad, d, m, rs;
        int pk[2];
        int dk[2];

        repeat (3) tick();
        chk("rst probe", int'(probe_out), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst timeout", int'(timeout), 0);
        chk("rst glitch", int'(glitch), 0);
        chk("rst dly_cnt", int'(dly_cnt), 0);
        reset = 1'b1;
        tick();

        measure("depth100", 100, 0, QUIET, 1'b0, 1'b0, -1);
        measure("tied low", -1, 0, QUIET, 1'b0, 1'b0, -1);
        measure("wire", 0, 0, QUIET, 1'b0, 1'b0, -1);
        measure("depth1", 1, 0, QUIET, 1'b0, 1'b0, -1);
        measure("depth128", 128, 0, QUIET, 1'b0, 1'b0, -1);
        measure("depth129", 129, 0, QUIET, 1'b0, 1'b0, -1);
        measure("flush glitch", 40, 20, 20 + QUIET, 1'b1, 1'b0, -1);
        measure("start in wait", 30, 0, QUIET, 1'b0, 1'b0, QUIET + 10);

        // start held high: back-to-back measurements, each with its own flush
        line_clr = 1'b1;
        tick();
        line_clr = 1'b0;
        depth = 20;
        start = 1'b1;
        k = 0; np = 0; nd = 0;
        pk[0] = 0; pk[1] = 0; dk[0] = 0; dk[1] = 0;
        while (nd < 2 && k < 200) begin
            tick();
            k++;
            if (probe_out && np < 2) begin
                pk[np] = k;
                np++;
            end
            if (done) begin
                dk[nd] = k;
                nd++;
                chk("held dly_cnt", int'(dly_cnt), 20);
                if (nd == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        exp_dly = 20;
        chk("held done count", nd, 2);
        chk("held probe1", pk[0], QUIET + 1);
        chk("held lat1", dk[0] - pk[0], 21);
        chk("held rearm", pk[1] - dk[0], QUIET + 1);
        chk("held lat2", dk[1] - pk[1], 21);
        tick();
        tick();
        chk("held idle", int'(busy), 0);

        // reset mid-WAIT, then remeasure once the stale echo lands in FLUSH
        line_clr = 1'b1;
        tick();
        line_clr = 1'b0;
        depth = 100;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!probe_out && k < 20) begin
            tick();
            k++;
        end
        chk("abort probe seen", int'(probe_out), 1);
        repeat (50) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_dly = 0;
        chk("abort probe", int'(probe_out), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort timeout", int'(timeout), 0);
        chk("abort glitch", int'(glitch), 0);
        chk("abort dly_cnt", int'(dly_cnt), 0);
        k = 0; nbad = 0;
        while (hist[97] !== 1'b1 && k < 200) begin
            tick();
            k++;
            if (done || timeout || busy) nbad++;
        end
        chk("abort no pulse", nbad, 0);
        chk("abort stale seen", int'(hist[97]), 1);
        measure("abort remeasure", 100, 0, QUIET + 2, 1'b1, 1'b1, -1);

        for (int i = 0; i < 12; i++) begin
            d = int'($urandom_range(0, 140));
            m = (d > MAX_DLY) ? MAX_DLY : d;
            rs = -1;
            if (m >= 2 && $urandom_range(0, 1) == 1) rs = QUIET + 1 + int'($urandom_range(0, m - 2));
            measure($sformatf("rand%0d d%0d", i, d), d, 0, QUIET, 1'b0, 1'b0, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
